// File: rtl/alu_arbiter_if.sv
// Requester/response channels between the two ALU clients and the arbiter.
// One request channel per requester; the response payload is shared and qualified by rspN_valid.
interface alu_arbiter_if #(
   parameter int DW  = 32,
   parameter int OPW = 4
);
   logic           req0_valid;
   logic           req0_ready;
   logic [DW-1:0]  req0_opa;
   logic [DW-1:0]  req0_opb;
   logic [OPW-1:0] req0_op;

   logic           req1_valid;
   logic           req1_ready;
   logic [DW-1:0]  req1_opa;
   logic [DW-1:0]  req1_opb;
   logic [OPW-1:0] req1_op;

   logic           rsp0_valid;
   logic           rsp0_ready;
   logic           rsp1_valid;
   logic           rsp1_ready;
   logic [DW-1:0]  rsp_result;
   logic           rsp_negative;
   logic           rsp_overflow;
   logic           rsp_zero;

   // The requesters and their response consumers.
   modport master (
      output req0_valid, req0_opa, req0_opb, req0_op,
      output req1_valid, req1_opa, req1_opb, req1_op,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_result, rsp_negative, rsp_overflow, rsp_zero
   );

   // The arbiter.
   modport slave (
      input  req0_valid, req0_opa, req0_opb, req0_op,
      input  req1_valid, req1_opa, req1_opb, req1_op,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_result, rsp_negative, rsp_overflow, rsp_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU between two requesters, one operation in flight.
// Operands are registered onto the ALU ports, the result is captured one cycle later and held until consumed.
module alu_arbiter #(
   parameter int DW  = 32,
   parameter int OPW = 4
) (
   input  logic           CLK,
   input  logic           RST,
   alu_arbiter_if.slave   bus,
   output logic [DW-1:0]  alu_porta,
   output logic [DW-1:0]  alu_portb,
   output logic [OPW-1:0] alu_op,
   input  logic [DW-1:0]  alu_result,
   input  logic           alu_negative,
   input  logic           alu_overflow,
   input  logic           alu_zero,
   output logic           busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state;
   logic           rr_last;
   logic           owner;
   logic           grant0;
   logic           grant1;
   logic           rsp0_valid_q;
   logic           rsp1_valid_q;
   logic [DW-1:0]  result_q;
   logic           negative_q;
   logic           overflow_q;
   logic           zero_q;
   logic           owner_rsp_ready;

   // rr_last names the previous winner, so on a tie the other requester goes next.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !RST) begin
         grant0 = bus.req0_valid && (!bus.req1_valid || rr_last);
         grant1 = bus.req1_valid && (!bus.req0_valid || !rr_last);
      end
   end

   assign bus.req0_ready   = grant0;
   assign bus.req1_ready   = grant1;
   assign bus.rsp0_valid   = rsp0_valid_q;
   assign bus.rsp1_valid   = rsp1_valid_q;
   assign bus.rsp_result   = result_q;
   assign bus.rsp_negative = negative_q;
   assign bus.rsp_overflow = overflow_q;
   assign bus.rsp_zero     = zero_q;
   assign owner_rsp_ready  = owner ? bus.rsp1_ready : bus.rsp0_ready;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         rr_last      <= 1'b1;
         owner        <= 1'b0;
         alu_porta    <= '0;
         alu_portb    <= '0;
         alu_op       <= '0;
         result_q     <= '0;
         negative_q   <= 1'b0;
         overflow_q   <= 1'b0;
         zero_q       <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0) begin
                  alu_porta <= bus.req0_opa;
                  alu_portb <= bus.req0_opb;
                  alu_op    <= bus.req0_op;
                  owner     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= EXEC;
               end else if (grant1) begin
                  alu_porta <= bus.req1_opa;
                  alu_portb <= bus.req1_opb;
                  alu_op    <= bus.req1_op;
                  owner     <= 1'b1;
                  busy      <= 1'b1;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               result_q     <= alu_result;
               negative_q   <= alu_negative;
               overflow_q   <= alu_overflow;
               zero_q       <= alu_zero;
               rsp0_valid_q <= !owner;
               rsp1_valid_q <= owner;
               state        <= RESP;
            end
            RESP: begin
               // Only the owner's ready completes the response; the other side is ignored.
               if (owner_rsp_ready) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  busy         <= 1'b0;
                  rr_last      <= owner;
                  state        <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter, with a small behavioural ALU on the ALU ports
// and a transaction-level reference model of the round-robin arbitration.
module tb_alu_arbiter;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;

   logic        CLK;
   logic        RST;
   logic [31:0] alu_porta;
   logic [31:0] alu_portb;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_negative;
   logic        alu_overflow;
   logic        alu_zero;
   logic        busy;

   int checks;
   int errors;
   int model_last;
   int obs_grant;
   logic [31:0] pa [2];
   logic [31:0] pb [2];
   logic [3:0]  pop [2];

   alu_arbiter_if #(.DW(32), .OPW(4)) bus ();

   alu_arbiter #(.DW(32), .OPW(4)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .bus          (bus.slave),
      .alu_porta    (alu_porta),
      .alu_portb    (alu_portb),
      .alu_op       (alu_op),
      .alu_result   (alu_result),
      .alu_negative (alu_negative),
      .alu_overflow (alu_overflow),
      .alu_zero     (alu_zero),
      .busy         (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Returns {negative, overflow, zero, result}; overflow judged on the true signed value.
   function automatic logic [34:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      longint sa;
      longint sb;
      longint wide;
      logic [31:0] r;
      logic v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v  = 1'b0;
      case (op)
         OP_ADD: begin wide = sa + sb; r = wide[31:0]; v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
         OP_SUB: begin wide = sa - sb; r = wide[31:0]; v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         default: r = a;
      endcase
      return {r[31], v, (r == 32'd0), r};
   endfunction

   always_comb {alu_negative, alu_overflow, alu_zero, alu_result} = ref_alu(alu_porta, alu_portb, alu_op);

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic new_operands(input int who);
      pa[who]  = $urandom;
      pb[who]  = $urandom;
      pop[who] = 4'($urandom_range(0, 4));
   endtask

   task automatic apply_stimulus(input int who, input logic v);
      if (who == 0) begin
         bus.req0_valid = v; bus.req0_opa = pa[0]; bus.req0_opb = pb[0]; bus.req0_op = pop[0];
      end else begin
         bus.req1_valid = v; bus.req1_opa = pa[1]; bus.req1_opb = pb[1]; bus.req1_op = pop[1];
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_output({tag, "_porta"}, alu_porta, 0);
      check_output({tag, "_portb"}, alu_portb, 0);
      check_output({tag, "_op"}, alu_op, 0);
      check_output({tag, "_result"}, bus.rsp_result, 0);
      check_output({tag, "_flags"}, {bus.rsp_negative, bus.rsp_overflow, bus.rsp_zero}, 0);
      check_output({tag, "_valids"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
      check_output({tag, "_readys"}, {bus.req0_ready, bus.req1_ready}, 0);
      check_output({tag, "_busy"}, busy, 0);
   endtask

   // One complete operation: arbitration, ALU issue, response with optional backpressure.
   task automatic transact(input logic v0, input logic v1, input int stall, input bit pulse);
      int w;
      int l;
      logic [34:0] exp_r;
      apply_stimulus(0, v0);
      apply_stimulus(1, v1);
      if (v0 && v1) w = (model_last == 1) ? 0 : 1;
      else          w = v1 ? 1 : 0;
      l = 1 - w;
      exp_r = ref_alu(pa[w], pb[w], pop[w]);
      #1;
      check_output("req0_ready_idle", bus.req0_ready, (w == 0));
      check_output("req1_ready_idle", bus.req1_ready, (w == 1));
      obs_grant = bus.req1_ready ? 1 : 0;
      tick();
      apply_stimulus(w, 1'b0);
      #1;
      check_output("exec_busy", busy, 1);
      check_output("exec_alu_ports", {alu_porta, alu_portb}, {pa[w], pb[w]});
      check_output("exec_alu_op", alu_op, pop[w]);
      check_output("exec_readys", {bus.req0_ready, bus.req1_ready}, 0);
      check_output("exec_rsp_valids", {bus.rsp0_valid, bus.rsp1_valid}, 0);
      tick();
      check_output("rsp_valids", {bus.rsp0_valid, bus.rsp1_valid}, {w == 0, w == 1});
      check_output("rsp_result", bus.rsp_result, exp_r[31:0]);
      check_output("rsp_flags", {bus.rsp_negative, bus.rsp_overflow, bus.rsp_zero}, exp_r[34:32]);
      for (int i = 0; i < stall; i++) begin
         if (w == 0) begin bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1; end
         else        begin bus.rsp1_ready = 1'b0; bus.rsp0_ready = 1'b1; end
         if (pulse && i == 0 && !(l == 0 ? v0 : v1)) begin
            new_operands(l);
            apply_stimulus(l, 1'b1);
         end
         #1;
         check_output("resp_readys", {bus.req0_ready, bus.req1_ready}, 0);
         tick();
         if (pulse && i == 0 && !(l == 0 ? v0 : v1)) apply_stimulus(l, 1'b0);
         check_output("hold_valids", {bus.rsp0_valid, bus.rsp1_valid}, {w == 0, w == 1});
         check_output("hold_result", bus.rsp_result, exp_r[31:0]);
         check_output("hold_flags", {bus.rsp_negative, bus.rsp_overflow, bus.rsp_zero}, exp_r[34:32]);
         check_output("hold_alu_ports", {alu_porta, alu_portb, 28'd0, alu_op}, {pa[w], pb[w], 28'd0, pop[w]});
         check_output("hold_busy", busy, 1);
      end
      bus.rsp0_ready = (w == 0);
      bus.rsp1_ready = (w == 1);
      tick();
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      check_output("done_busy", busy, 0);
      check_output("done_valids", {bus.rsp0_valid, bus.rsp1_valid}, 0);
      model_last = w;
      new_operands(w);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      model_last = 1;
   endtask

   initial begin
      logic v0;
      logic v1;
      checks = 0;
      errors = 0;
      obs_grant = 0;
      RST = 1'b1;
      for (int k = 0; k < 2; k++) new_operands(k);
      apply_stimulus(0, 1'b0);
      apply_stimulus(1, 1'b0);
      do_reset();
      check_all_zero("reset");

      // Single ADD from requester 0.
      pa[0] = 32'h5; pb[0] = 32'h3; pop[0] = OP_ADD;
      transact(1'b1, 1'b0, 0, 1'b0);

      // Both valid straight out of reset: 0 wins first, then the pending ADD overflow from 1.
      do_reset();
      pa[0] = 32'h1;        pb[0] = 32'h1; pop[0] = OP_SUB;
      pa[1] = 32'h7FFFFFFF; pb[1] = 32'h1; pop[1] = OP_ADD;
      transact(1'b1, 1'b1, 0, 1'b0);
      check_output("tie_first_grant", obs_grant, 0);
      transact(1'b0, 1'b1, 0, 1'b0);

      // Fairness: grants must alternate 0,1,0,1,0,1.
      for (int i = 0; i < 6; i++) begin
         transact(1'b1, 1'b1, 0, 1'b0);
         check_output("fair_grant", obs_grant, i % 2);
      end

      // Backpressure on requester 1 while requester 0 waits; rsp0_ready toggled high is ignored.
      transact(1'b1, 1'b0, 0, 1'b0);
      transact(1'b1, 1'b1, 5, 1'b0);
      check_output("bp_grant", obs_grant, 1);
      transact(1'b1, 1'b0, 0, 1'b0);

      // Requester 0 pulses valid during requester 1's response phase.
      transact(1'b0, 1'b1, 3, 1'b1);

      // Reset in the middle of an operation.
      apply_stimulus(0, 1'b1);
      tick();
      check_output("pre_abort_busy", busy, 1);
      RST = 1'b1;
      apply_stimulus(0, 1'b0);
      tick();
      check_all_zero("abort");
      RST = 1'b0;
      model_last = 1;
      tick();
      check_output("post_abort_busy", busy, 0);
      check_output("post_abort_valids", {bus.rsp0_valid, bus.rsp1_valid}, 0);
      transact(1'b0, 1'b1, 0, 1'b0);

      // Random mix of requesters and response stalls.
      for (int i = 0; i < 20; i++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         transact(v0, v1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end
      apply_stimulus(0, 1'b0);
      apply_stimulus(1, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
